// File: rtl/queue_uart_pkg.sv
// Shared types and constants for the queue-draining UART transmitter.
// Contents: FSM state encoding, data width, queue read/write select codes.
package queue_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int unsigned DATA_BITS = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/queue_uart_if.sv
// Read-side connection between the RAM queue and its drain stage.
// Signals: q_en / q_rw   - pop strobe and read/write select (drain stage drives)
//          q_empty       - queue empty flag (queue drives)
//          q_data        - queue output byte, valid one cycle after q_en (queue drives)
interface queue_uart_if;
    import queue_uart_pkg::*;

    logic                 q_en;
    logic                 q_rw;
    logic                 q_empty;
    logic [DATA_BITS-1:0] q_data;

    modport master (
        output q_en,
        output q_rw,
        input  q_empty,
        input  q_data
    );

    modport slave (
        input  q_en,
        input  q_rw,
        output q_empty,
        output q_data
    );

endinterface

// File: rtl/queue_uart_tx_baud_tick.sv
// Bit-period timer: free-running count 0..CLKS_PER_BIT-1 that wraps.
// Ports: clk, reset (sync, active-high), clear (hold count at 0),
//        tick (high during the last cycle of each bit period).
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             last_c;

    assign last_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Wrap on the last count; clear holds the counter at zero between timed states.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (last_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = last_c;

endmodule

// File: rtl/queue_uart_tx.sv
// Drain stage after the RAM queue: pops one byte whenever the queue is
// non-empty and transmit is enabled, and sends it as a serial frame
// (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
// Ports: clk, reset (sync, active-high), tx_enable (allows new frames),
//        q (queue read port, master side), tx (serial line, idles high),
//        busy (high outside IDLE).
module queue_uart_tx
    import queue_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_enable,
    queue_uart_if.master      q,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    state_t               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_CNT_W-1:0] bit_q;
    logic                 parity_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 q_en_q;

    logic                 tick;
    logic                 baud_clear_c;
    logic                 start_pop_c;

    // Untimed states keep the baud counter at zero so every timed state starts fresh.
    assign baud_clear_c = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);
    assign start_pop_c  = tx_enable && !q.q_empty;

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear_c),
        .tick  (tick)
    );

    // Frame sequencer; tx/busy/q_en are set on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            q_en_q   <= 1'b0;
        end else begin
            q_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_pop_c) begin
                        state_q <= ST_POP;
                        q_en_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_POP: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Queue has one cycle of read latency, so the byte is valid here.
                    shift_q  <= q.q_data;
                    parity_q <= (^q.q_data) ^ PARITY_ODD;
                    bit_q    <= '0;
                    tx_q     <= 1'b0;
                    state_q  <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY_EN) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_CNT_W'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // bit_q counts stop bits; q_empty is re-sampled only at the very end.
                    if (tick) begin
                        if (bit_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                            bit_q <= '0;
                            if (start_pop_c) begin
                                state_q <= ST_POP;
                                q_en_q  <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign busy   = busy_q;
    assign q.q_en = q_en_q;
    assign q.q_rw = RW_READ;

endmodule
